pipe_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the CPU core. It merges per-stage stall requests into a prefix stall vector and marks the bubble-insertion point. It runs a registered flush/redirect sequence and monitors stall length with a watchdog and a performance counter. It sits beside the pipeline registers and drives their stall, flush and bubble controls plus the PC redirect.

---
 rtl/pipe_ctrl_if.sv | 29 ++
 rtl/pipe_ctrl.sv | 93 +++++++++
 tb/tb_pipe_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Hazard-control bus between the pipeline and pipe_ctrl.
//   stallreq/flush_req/flush_pc/perf_clr : pipeline -> controller requests
//   stall/bubble/flush/new_pc/new_pc_valid : controller -> pipeline registers and PC
//   wdog_timeout/stall_total               : stall monitoring
interface pipe_ctrl_if #(
  parameter int STAGES = 6,
  parameter int PC_W   = 32
);
  logic [STAGES-1:0] stallreq;
  logic              flush_req;
  logic [PC_W-1:0]   flush_pc;
  logic              perf_clr;
  logic [STAGES-1:0] stall;
  logic [STAGES-1:0] bubble;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              new_pc_valid;
  logic              wdog_timeout;
  logic [31:0]       stall_total;

  modport master (
    output stallreq, flush_req, flush_pc, perf_clr,
    input  stall, bubble, flush, new_pc, new_pc_valid, wdog_timeout, stall_total
  );
  modport slave (
    input  stallreq, flush_req, flush_pc, perf_clr,
    output stall, bubble, flush, new_pc, new_pc_valid, wdog_timeout, stall_total
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : pipe_ctrl_if slave; stall requests in, prefix stall / bubble,
//              registered flush + PC redirect, stall watchdog and stall counter out.
module pipe_ctrl #(
  parameter int STAGES       = 6,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int WDOG_LIMIT   = 64,
  parameter int WDOG_W       = 8
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0]     FC_M1  = CW'(FLUSH_CYCLES - 1);
  localparam logic [WDOG_W-1:0] LIM_M1 = WDOG_W'(WDOG_LIMIT - 1);
  localparam logic [WDOG_W-1:0] WMAX   = '1;

  typedef enum logic {S_IDLE, S_FLUSH} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [PC_W-1:0]   r_pc;
  logic              r_npv;
  logic [WDOG_W-1:0] r_wcnt;
  logic              r_wto;
  logic [31:0]       r_tot;

  logic [STAGES-1:0] w_above;  // w_above[j]: some stage at index >= j requests a stall
  logic [STAGES-1:0] w_bub;
  logic              w_flush;
  logic              w_hold;
  logic [STAGES-1:0] w_stall;

  // Everything at or below the highest requester holds; the stage just above it
  // is the one whose input has gone stale, so it receives the bubble.
  assign w_above[STAGES-1] = bus.stallreq[STAGES-1];
  assign w_bub[0]          = 1'b0;
  for (genvar j = 0; j < STAGES - 1; j++) begin : g_merge
    assign w_above[j]  = bus.stallreq[j] | w_above[j+1];
    assign w_bub[j+1]  = w_above[j] & ~w_above[j+1];
  end

  assign w_flush = (r_state == S_FLUSH);
  assign w_hold  = rst & ~w_flush;  // flush beats stall; reset kills both
  assign w_stall = w_above & {STAGES{w_hold}};

  assign bus.stall        = w_stall;
  assign bus.bubble       = w_bub & {STAGES{w_hold}};
  assign bus.flush        = w_flush;
  assign bus.new_pc       = r_pc;
  assign bus.new_pc_valid = r_npv;
  assign bus.wdog_timeout = r_wto;
  assign bus.stall_total  = r_tot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_npv   <= 1'b0;
    end else begin
      r_npv <= 1'b0;
      if (bus.flush_req) begin
        // Accepted from either state; the newest redirect always wins.
        r_state <= S_FLUSH;
        r_cnt   <= FC_M1;
        r_pc    <= bus.flush_pc;
        r_npv   <= 1'b1;
      end else if (r_state == S_FLUSH) begin
        if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
        else             r_state <= S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt <= '0;
      r_wto  <= 1'b0;
      r_tot  <= '0;
    end else begin
      // Fires only on the LIMIT-1 -> LIMIT step; saturation keeps it from re-firing.
      r_wto <= w_stall[0] && (r_wcnt == LIM_M1);
      if (!w_stall[0])       r_wcnt <= '0;
      else if (r_wcnt != WMAX) r_wcnt <= r_wcnt + 1'b1;
      if (bus.perf_clr) r_tot <= '0;
      else              r_tot <= r_tot + 32'(w_stall[0]);
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
  localparam int S  = 6;
  localparam int FC = 2;
  localparam int WL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.STAGES(S), .PC_W(32)) bus ();
  pipe_ctrl #(.STAGES(S), .PC_W(32), .FLUSH_CYCLES(FC), .WDOG_LIMIT(WL), .WDOG_W(8))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // reference model state (behavioural: remaining flush cycles, run length, totals)
  int          m_fl;
  logic [31:0] m_pc;
  logic        m_npv;
  int          m_run;
  logic        m_wto;
  logic [31:0] m_tot;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    m_fl = 0; m_pc = '0; m_npv = 1'b0; m_run = 0; m_wto = 1'b0; m_tot = '0;
  endtask

  function automatic logic [S-1:0] exp_stall(input logic [S-1:0] sr);
    int k = -1;
    for (int i = 0; i < S; i++) if (sr[i]) k = i;
    if (k < 0) return '0;
    return S'((1 << (k + 1)) - 1);
  endfunction

  function automatic logic [S-1:0] exp_bubble(input logic [S-1:0] sr);
    int k = -1;
    for (int i = 0; i < S; i++) if (sr[i]) k = i;
    if (k < 0 || k + 1 >= S) return '0;
    return S'(1 << (k + 1));
  endfunction

  task automatic drive(input logic [S-1:0] sr, input logic fr, input logic [31:0] fp, input logic pc);
    bus.stallreq = sr; bus.flush_req = fr; bus.flush_pc = fp; bus.perf_clr = pc;
    #1;
  endtask

  // compare against model, clock once, advance model
  task automatic tick();
    logic [S-1:0] es;
    logic         s0;
    es = (m_fl > 0) ? '0 : exp_stall(bus.stallreq);
    chk("m_stall",  32'(bus.stall),  32'(es));
    chk("m_bubble", 32'(bus.bubble), (m_fl > 0) ? 32'd0 : 32'(exp_bubble(bus.stallreq)));
    chk("m_flush",  32'(bus.flush),  32'(m_fl > 0));
    chk("m_npv",    32'(bus.new_pc_valid), 32'(m_npv));
    chk("m_newpc",  bus.new_pc, m_pc);
    chk("m_wdog",   32'(bus.wdog_timeout), 32'(m_wto));
    chk("m_total",  bus.stall_total, m_tot);
    s0 = es[0];
    @(posedge clk);
    if (bus.flush_req) begin m_fl = FC; m_pc = bus.flush_pc; m_npv = 1'b1; end
    else begin m_fl = (m_fl > 0) ? m_fl - 1 : 0; m_npv = 1'b0; end
    m_wto = s0 && (m_run + 1 == WL);
    m_run = s0 ? m_run + 1 : 0;
    m_tot = bus.perf_clr ? 32'd0 : m_tot + 32'(s0);
    @(negedge clk);
  endtask

  task automatic cyc(input logic [S-1:0] sr, input logic fr, input logic [31:0] fp, input logic pc);
    drive(sr, fr, fp, pc);
    tick();
  endtask

  typedef struct { logic [S-1:0] sr; logic [S-1:0] st; logic [S-1:0] bb; } vec_t;
  vec_t vt[8];

  initial begin
    vt[0] = '{6'b000010, 6'b000011, 6'b000100};
    vt[1] = '{6'b001001, 6'b001111, 6'b010000};
    vt[2] = '{6'b000000, 6'b000000, 6'b000000};
    vt[3] = '{6'b001000, 6'b001111, 6'b010000};
    vt[4] = '{6'b100000, 6'b111111, 6'b000000};
    vt[5] = '{6'b000001, 6'b000001, 6'b000010};
    vt[6] = '{6'b010100, 6'b011111, 6'b100000};
    vt[7] = '{6'b111111, 6'b111111, 6'b000000};

    // reset with everything requested
    m_reset();
    drive(6'b111111, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_bubble", 32'(bus.bubble), 0);
    chk("rst_flush", 32'(bus.flush), 0);
    chk("rst_npv", 32'(bus.new_pc_valid), 0);
    chk("rst_total", bus.stall_total, 0);
    chk("rst_newpc", bus.new_pc, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    drive(6'b111111, 1'b0, 32'h0, 1'b0);
    chk("rel_stall", 32'(bus.stall), 32'h3F);
    chk("rel_bubble", 32'(bus.bubble), 0);
    tick();

    // table-driven merge vectors
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].sr, 1'b0, 32'h0, 1'b0);
      chk($sformatf("vec%0d_stall", i), 32'(bus.stall), 32'(vt[i].st));
      chk($sformatf("vec%0d_bubble", i), 32'(bus.bubble), 32'(vt[i].bb));
      tick();
    end

    // single flush under stall
    cyc(6'b000111, 1'b1, 32'h0000_1000, 1'b0);
    drive(6'b000111, 1'b0, 32'h0, 1'b0);
    chk("fl1_flush", 32'(bus.flush), 1);
    chk("fl1_stall", 32'(bus.stall), 0);
    chk("fl1_bubble", 32'(bus.bubble), 0);
    chk("fl1_pc", bus.new_pc, 32'h1000);
    chk("fl1_npv", 32'(bus.new_pc_valid), 1);
    tick();
    drive(6'b000111, 1'b0, 32'h0, 1'b0);
    chk("fl2_flush", 32'(bus.flush), 1);
    chk("fl2_npv", 32'(bus.new_pc_valid), 0);
    tick();
    drive(6'b000111, 1'b0, 32'h0, 1'b0);
    chk("fl3_flush", 32'(bus.flush), 0);
    chk("fl3_stall", 32'(bus.stall), 32'h07);
    chk("fl3_pc_hold", bus.new_pc, 32'h1000);
    tick();

    // back-to-back flush: second request in the first flush cycle
    cyc(6'b0, 1'b1, 32'h0000_1000, 1'b0);
    drive(6'b0, 1'b1, 32'h0000_2000, 1'b0);
    chk("bb_npv1", 32'(bus.new_pc_valid), 1);
    tick();
    drive(6'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_pc", bus.new_pc, 32'h2000);
    chk("bb_npv2", 32'(bus.new_pc_valid), 1);
    chk("bb_flush_a", 32'(bus.flush), 1);
    tick();
    drive(6'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_flush_b", 32'(bus.flush), 1);
    chk("bb_npv3", 32'(bus.new_pc_valid), 0);
    tick();
    drive(6'b0, 1'b0, 32'h0, 1'b0);
    chk("bb_flush_end", 32'(bus.flush), 0);
    tick();

    // watchdog: 10 stall cycles, pulse in cycle 5 only
    cyc(6'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      drive(6'b000001, 1'b0, 32'h0, 1'b0);
      chk($sformatf("wd_c%0d", i), 32'(bus.wdog_timeout), 32'(i == 5));
      tick();
    end
    drive(6'b0, 1'b0, 32'h0, 1'b0);
    chk("wd_total10", bus.stall_total, 32'd10);
    chk("wd_after", 32'(bus.wdog_timeout), 0);
    tick();
    for (int i = 0; i < 4; i++) cyc(6'b000001, 1'b0, 32'h0, 1'b0);
    drive(6'b0, 1'b0, 32'h0, 1'b0);
    chk("wd_refire", 32'(bus.wdog_timeout), 1);
    tick();

    // perf_clr wins over a simultaneous stall
    cyc(6'b000001, 1'b0, 32'h0, 1'b1);
    drive(6'b0, 1'b0, 32'h0, 1'b0);
    chk("clr_wins", bus.stall_total, 0);
    tick();

    // reset in the middle of a flush: nothing pending afterwards
    cyc(6'b000011, 1'b1, 32'h0000_3000, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_flush", 32'(bus.flush), 0);
    chk("mrst_npv", 32'(bus.new_pc_valid), 0);
    chk("mrst_stall", 32'(bus.stall), 0);
    chk("mrst_pc", bus.new_pc, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    m_reset();
    drive(6'b000011, 1'b0, 32'h0, 1'b0);
    chk("mrst_rel_flush", 32'(bus.flush), 0);
    chk("mrst_rel_stall", 32'(bus.stall), 32'h03);
    tick();

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [S-1:0] sr;
      sr = ($urandom_range(0, 3) == 0) ? '0 : S'($urandom) & S'($urandom);
      if ($urandom_range(0, 4) == 0) sr = 6'b000001;
      cyc(sr, $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
